// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache.
// Hits answer combinationally; misses fetch one 256-bit line.
module inst_cache #(
  parameter int S_INDEX  = 3,
  parameter int S_OFFSET = 5,
  parameter int S_TAG    = 32 - S_INDEX - S_OFFSET
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inst_read,
  input  logic [31:0]  inst_addr,
  output logic [31:0]  inst_rdata,
  output logic         inst_resp,
  output logic [31:0]  pmem_address,
  output logic         pmem_read,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
);

  localparam int LINES = 1 << S_INDEX;
  localparam int S_LA  = S_TAG + S_INDEX;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FILLED
  } state_t;

  state_t state_q, state_d;

  logic [S_LA-1:0]    miss_addr_q, miss_addr_d;
  logic [31:0]        hit_count_q, hit_count_d;
  logic [31:0]        miss_count_q, miss_count_d;

  logic [LINES-1:0]   valid_q, valid_d;
  logic [S_TAG-1:0]   tag_q  [LINES];
  logic [255:0]       data_q [LINES];

  logic [S_TAG-1:0]   req_tag;
  logic [S_INDEX-1:0] req_idx;
  logic [2:0]         req_word;
  logic [S_INDEX-1:0] miss_idx;
  logic [S_TAG-1:0]   miss_tag;
  logic               hit;
  logic               fill_en;
  logic [31:0]        hit_word;
  logic               unused_addr;

  assign req_tag  = inst_addr[31:S_OFFSET+S_INDEX];
  assign req_idx  = inst_addr[S_OFFSET+S_INDEX-1:S_OFFSET];
  assign req_word = inst_addr[4:2];
  assign miss_idx = miss_addr_q[S_INDEX-1:0];
  assign miss_tag = miss_addr_q[S_LA-1:S_INDEX];

  // Byte lanes within a word are never selected separately.
  assign unused_addr = ^inst_addr[1:0];

  // Tag compare and word select on the indexed line.
  always_comb begin
    hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    hit_word = data_q[req_idx][{req_word, 5'd0} +: 32];
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d      = state_q;
    miss_addr_d  = miss_addr_q;
    inst_resp    = 1'b0;
    inst_rdata   = 32'd0;
    pmem_read    = 1'b0;
    pmem_address = 32'd0;
    fill_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (inst_read) begin
          if (hit) begin
            inst_resp  = 1'b1;
            inst_rdata = hit_word;
          end else begin
            miss_addr_d = inst_addr[31:S_OFFSET];
            state_d     = FETCH;
          end
        end
      end
      FETCH: begin
        pmem_read    = 1'b1;
        pmem_address = {miss_addr_q, {S_OFFSET{1'b0}}};
        if (pmem_resp) begin
          fill_en = 1'b1;
          state_d = FILLED;
        end
      end
      FILLED: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Valid bits set on fill; only reset clears them.
  always_comb begin
    valid_d = valid_q;
    if (fill_en) begin
      valid_d[miss_idx] = 1'b1;
    end
  end

  // Saturating performance counters.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (inst_resp && (hit_count_q != 32'hFFFF_FFFF)) begin
      hit_count_d = hit_count_q + 32'd1;
    end
    if (fill_en && (miss_count_q != 32'hFFFF_FFFF)) begin
      miss_count_d = miss_count_q + 32'd1;
    end
  end

  // Control state, valid bits and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      miss_addr_q  <= '0;
      valid_q      <= '0;
      hit_count_q  <= 32'd0;
      miss_count_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      miss_addr_q  <= miss_addr_d;
      valid_q      <= valid_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Tag and data arrays: written on fill, never reset.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[miss_idx]  <= miss_tag;
      data_q[miss_idx] <= pmem_rdata;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache.
// Vector table for hits plus hand sequences for misses.
module tb_inst_cache;

  logic         clk;
  logic         rst;
  logic         inst_read;
  logic [31:0]  inst_addr;
  logic [31:0]  inst_rdata;
  logic         inst_resp;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  int errors = 0;
  int checks = 0;
  int exp_hits = 0;

  inst_cache dut (
    .clk          (clk),
    .rst          (rst),
    .inst_read    (inst_read),
    .inst_addr    (inst_addr),
    .inst_rdata   (inst_rdata),
    .inst_resp    (inst_resp),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic [31:0] addr;
    logic        exp_resp;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] line_of(input logic [31:0] a);
    logic [255:0] r;
    logic [31:0]  b;
    b = {a[31:5], 5'd0};
    for (int k = 0; k < 8; k++) begin
      r[k*32 +: 32] = 32'h1000_0000 + b + 32'(k);
    end
    return r;
  endfunction

  // Request a missing line; memory answers in the lat-th FETCH cycle.
  // Returns in the IDLE cycle after FILLED with the request still up.
  task automatic miss_fill(input logic [31:0] a, input int lat);
    inst_read = 1'b1;
    inst_addr = a;
    #3;
    chk("miss_req_resp", 32'(inst_resp), 32'd0);
    step();
    chk("miss_pmem_read", 32'(pmem_read), 32'd1);
    chk("miss_pmem_addr", pmem_address, {a[31:5], 5'd0});
    for (int i = 1; i < lat; i++) begin
      step();
      chk("miss_hold", 32'(pmem_read), 32'd1);
    end
    pmem_rdata = line_of(a);
    pmem_resp  = 1'b1;
    step();
    pmem_resp  = 1'b0;
    chk("filled_pmem_read", 32'(pmem_read), 32'd0);
    chk("filled_resp", 32'(inst_resp), 32'd0);
    step();
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0000, 1'b1, 32'h1000_0000};
    vecs[1] = '{1'b1, 32'h0000_001C, 1'b1, 32'h1000_0007};
    vecs[2] = '{1'b1, 32'h0000_0004, 1'b1, 32'h1000_0001};
    vecs[3] = '{1'b0, 32'h0000_0008, 1'b0, 32'h0000_0000};
    vecs[4] = '{1'b1, 32'h0000_0011, 1'b1, 32'h1000_0004};

    rst        = 1'b1;
    inst_read  = 1'b0;
    inst_addr  = 32'd0;
    pmem_rdata = '0;
    pmem_resp  = 1'b0;

    #3;
    chk("rst_resp", 32'(inst_resp), 32'd0);
    chk("rst_rdata", inst_rdata, 32'd0);
    chk("rst_pmem_read", 32'(pmem_read), 32'd0);
    chk("rst_pmem_addr", pmem_address, 32'd0);
    chk("rst_hits", hit_count, 32'd0);
    chk("rst_misses", miss_count, 32'd0);
    #9;
    rst = 1'b0;
    step();

    // Cold miss, 3-cycle memory.
    miss_fill(32'h0000_0008, 3);
    #3;
    chk("cold_resp", 32'(inst_resp), 32'd1);
    chk("cold_rdata", inst_rdata, 32'h1000_0002);
    chk("cold_misses", miss_count, 32'd1);
    chk("cold_hits", hit_count, 32'd0);
    step();
    exp_hits++;

    // Back-to-back hits on the filled line.
    for (int i = 0; i < 5; i++) begin
      inst_read = vecs[i].rd;
      inst_addr = vecs[i].addr;
      #3;
      chk($sformatf("vec%0d_resp", i), 32'(inst_resp),
          32'(vecs[i].exp_resp));
      chk($sformatf("vec%0d_rdata", i), inst_rdata, vecs[i].exp_data);
      chk($sformatf("vec%0d_pmem", i), 32'(pmem_read), 32'd0);
      step();
      if (vecs[i].exp_resp) exp_hits++;
    end
    chk("vec_hits", hit_count, 32'(exp_hits));

    // Conflict: same index, different tag, then back again.
    miss_fill(32'h0000_0100, 2);
    #3;
    chk("conf_resp", 32'(inst_resp), 32'd1);
    chk("conf_rdata", inst_rdata, 32'h1000_0100);
    chk("conf_misses", miss_count, 32'd2);
    step();
    exp_hits++;
    miss_fill(32'h0000_0000, 1);
    #3;
    chk("evict_rdata", inst_rdata, 32'h1000_0000);
    chk("evict_misses", miss_count, 32'd3);
    step();
    exp_hits++;

    // Request withdrawn and changed during FETCH.
    inst_read = 1'b1;
    inst_addr = 32'h0000_0040;
    #3;
    chk("drop_req_resp", 32'(inst_resp), 32'd0);
    step();
    chk("drop_pmem_read", 32'(pmem_read), 32'd1);
    chk("drop_pmem_addr", pmem_address, 32'h0000_0040);
    inst_read = 1'b0;
    inst_addr = 32'h0000_0080;
    #3;
    chk("drop_fetch_resp", 32'(inst_resp), 32'd0);
    step();
    chk("drop_hold_read", 32'(pmem_read), 32'd1);
    chk("drop_hold_addr", pmem_address, 32'h0000_0040);
    pmem_rdata = line_of(32'h0000_0040);
    pmem_resp  = 1'b1;
    step();
    pmem_resp  = 1'b0;
    chk("drop_filled_resp", 32'(inst_resp), 32'd0);
    chk("drop_filled_read", 32'(pmem_read), 32'd0);
    step();
    chk("drop_idle_resp", 32'(inst_resp), 32'd0);
    chk("drop_misses", miss_count, 32'd4);
    chk("drop_hits", hit_count, 32'(exp_hits));
    inst_read = 1'b1;
    inst_addr = 32'h0000_0040;
    #3;
    chk("rereq_resp", 32'(inst_resp), 32'd1);
    chk("rereq_rdata", inst_rdata, 32'h1000_0040);
    chk("rereq_pmem", 32'(pmem_read), 32'd0);
    step();
    exp_hits++;
    chk("rereq_hits", hit_count, 32'(exp_hits));

    // Reset while the line read is outstanding.
    inst_addr = 32'h0000_0200;
    #3;
    step();
    chk("rfetch_read", 32'(pmem_read), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rfetch_drop", 32'(pmem_read), 32'd0);
    chk("rfetch_addr", pmem_address, 32'd0);
    chk("rfetch_hits", hit_count, 32'd0);
    chk("rfetch_misses", miss_count, 32'd0);
    inst_read = 1'b0;
    #3;
    rst = 1'b0;
    step();
    pmem_rdata = line_of(32'h0000_0200);
    pmem_resp  = 1'b1;
    step();
    pmem_resp  = 1'b0;
    chk("stray_pmem_read", 32'(pmem_read), 32'd0);
    step();
    chk("stray_misses", miss_count, 32'd0);
    exp_hits = 0;
    miss_fill(32'h0000_0200, 1);
    #3;
    chk("post_rst_rdata", inst_rdata, 32'h1000_0200);
    chk("post_rst_misses", miss_count, 32'd1);
    step();
    exp_hits++;
    miss_fill(32'h0000_0000, 1);
    #3;
    chk("post_rst_old_misses", miss_count, 32'd2);
    step();
    exp_hits++;
    chk("post_rst_hits", hit_count, 32'(exp_hits));

    // Hit counter saturation.
    inst_read = 1'b0;
    force dut.hit_count_q = 32'hFFFF_FFFE;
    step();
    step();
    release dut.hit_count_q;
    #3;
    chk("sat_preset", hit_count, 32'hFFFF_FFFE);
    inst_read = 1'b1;
    inst_addr = 32'h0000_0000;
    step();
    chk("sat_first", hit_count, 32'hFFFF_FFFF);
    step();
    step();
    chk("sat_hold", hit_count, 32'hFFFF_FFFF);
    inst_read = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_cache.md
Name: inst_cache

Overview:
Direct-mapped, read-only instruction cache. It is the responder for the fetch stage's instruction request, driven by inst_read/inst_addr. A hit returns the 32-bit instruction word in the same cycle. A miss fetches one 256-bit line from physical memory over a single-beat pmem read handshake, fills the line, then completes on the following cycle. Includes saturating hit and miss counters for performance measurement.

Parameters:
S_INDEX, 3, number of index bits; the cache has 2**S_INDEX lines.
S_OFFSET, 5, byte-offset bits per line (fixed 32-byte, 256-bit line).
S_TAG, 32-S_INDEX-S_OFFSET, tag width (derived).

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
inst_read  in  1  fetch request valid
inst_addr  in  32  byte address of instruction; bits [1:0] ignored
inst_rdata  out  32  instruction word; valid only when inst_resp=1
inst_resp  out  1  request serviced this cycle
pmem_address  out  32  line-aligned memory address (bits [4:0]=0)
pmem_read  out  1  line read request to memory
pmem_rdata  in  256  line data from memory; word k at bits [32k+31:32k]
pmem_resp  in  1  memory line data valid, one-cycle pulse
hit_count  out  32  saturating count of hit responses
miss_count  out  32  saturating count of line fills

Behaviour:
- Address split: offset=addr[4:0], word select=addr[4:2], index=addr[S_OFFSET+S_INDEX-1:S_OFFSET], tag=addr[31:S_OFFSET+S_INDEX].
- Storage: per line a valid bit, an S_TAG tag, and 256 data bits, held in flip-flop arrays with asynchronous read and synchronous write. No replacement choice: the indexed line is overwritten.
- Reset, asynchronous and immediate: all valid bits 0, state=IDLE, inst_resp=0, inst_rdata=0, pmem_read=0, pmem_address=0, hit_count=0, miss_count=0. Tag and data arrays are not reset.
- FSM states: IDLE, FETCH, FILLED.
- IDLE:
  - On inst_read=1 with the indexed line valid and tags equal, this is a hit. inst_resp=1 combinationally, inst_rdata=the selected word, and hit_count increments at the clock edge. State stays IDLE.
  - On inst_read=1 with no hit, the cache latches {tag,index} into miss_addr and moves to FETCH. inst_resp=0.
  - On inst_read=0, outputs are 0 and the state is unchanged.
- FETCH:
  - pmem_read=1 and pmem_address={miss_addr,5'b0}, both held until pmem_resp.
  - On pmem_resp=1, the cache writes pmem_rdata into line[miss index], sets valid=1, writes the tag, increments miss_count, and moves to FILLED. pmem_read drops in the cycle after pmem_resp.
- FILLED: lasts one cycle, then returns to IDLE unconditionally. In the IDLE cycle that follows, a request to the same address hits and responds. Total miss latency to inst_resp is (memory latency)+2 cycles from the request cycle.
- inst_resp is never asserted in FETCH or FILLED.
- Request changes or drops during FETCH: the fill still completes using the latched miss_addr. The transaction is never abandoned, and no response is issued for a request that has gone away. A new address is evaluated only after the return to IDLE.
- Reset during FETCH: pmem_read drops immediately and the state returns to IDLE. A pmem_resp arriving after reset while in IDLE is ignored and causes no array write.
- Counters saturate at 32'hFFFF_FFFF and never wrap.
- No write port. Self-modifying code is unsupported; only reset invalidates the cache.

Test Plan:
- Cold miss, with memory returning a 3-cycle-latency line whose word k=32'h1000_0000+k: read 0x0000_0008 -> pmem_read=1 with pmem_address=0x0000_0000 until resp. Then FILLED, then inst_resp=1 with inst_rdata=32'h1000_0002; miss_count=1.
- Same-line hits: read 0x0000_0000, 0x0000_001C, 0x0000_0004 back-to-back -> inst_resp=1 each cycle with words 0, 7, 1; no pmem_read; hit_count=3.
- Conflict eviction with S_INDEX=3: fill line at 0x0000_0000, then read 0x0000_0100 (same index, different tag) -> miss and refill. A later read of 0x0000_0000 misses again; miss_count increments each time.
- Request dropped mid-fetch: miss on 0x0000_0040, deassert inst_read after 1 cycle, memory responds -> line 2 valid, no inst_resp issued. A re-request of 0x0000_0040 then hits immediately.
- Reset mid-fetch: assert rst while pmem_read=1 -> pmem_read=0 in the same cycle. A stray pmem_resp after reset writes nothing. A read of the previously cached address misses because all valid bits are cleared.
- Counter saturation: force hit_count to 32'hFFFF_FFFE and issue 3 hits -> reads 32'hFFFF_FFFF and holds.
